// File: rtl/mdu_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
// Op and state codes are plain localparams so legacy decode logic can use them directly.
package mdu_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    // Counter start value: 32 iterations run with the counter going 31 down to 0.
    localparam logic [4:0] LAST_ITER = 5'd31;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic c);
        return c ? 32'(-v) : v;
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_addsub.sv
// 33-bit adder/subtractor shared by the shift-add multiply and restoring divide steps.
// For subtraction, carry_o=1 means no borrow (x_i >= y_i).
module mdu_addsub (
    input  logic [32:0] x_i,
    input  logic [32:0] y_i,
    input  logic        sub_i,
    output logic [32:0] sum_o,
    output logic        carry_o
);

    logic [33:0] full;

    assign full    = {1'b0, x_i} + {1'b0, (sub_i ? ~y_i : y_i)} + 34'(sub_i);
    assign sum_o   = full[32:0];
    assign carry_o = full[33];

endmodule

// File: rtl/mdu.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one bit per cycle on operand
// magnitudes, sign fix-up in a final cycle, fixed 33-cycle busy window.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    // acc: product high word / partial remainder; wrk: multiplier / quotient bits;
    // opnd: multiplicand / divisor magnitude.
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   wrk_q, wrk_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;

    logic               is_div;
    logic               sgn;
    logic [WIDTH:0]     as_x, as_y, as_sum, mul_sum;
    logic               as_carry;
    logic [2*WIDTH-1:0] prod;

    assign is_div = is_div_op(op_q);
    assign sgn    = is_signed_op(op_q);

    // Divide feeds the shifted remainder; multiply feeds the running high word.
    assign as_x = is_div ? {acc_q, wrk_q[WIDTH-1]} : {1'b0, acc_q};
    assign as_y = {1'b0, opnd_q};

    mdu_addsub u_addsub (
        .x_i    (as_x),
        .y_i    (as_y),
        .sub_i  (is_div),
        .sum_o  (as_sum),
        .carry_o(as_carry)
    );

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opnd_d  = opnd_q;
        mul_sum = wrk_q[0] ? as_sum : {1'b0, acc_q};
        prod    = {acc_q, wrk_q};

        case (state_q)
            IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    wrk_d   = neg_if(a, is_signed_op(op) && a[WIDTH-1]);
                    opnd_d  = neg_if(b, is_signed_op(op) && b[WIDTH-1]);
                    cnt_d   = LAST_ITER;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (is_div) begin
                    acc_d = as_carry ? as_sum[WIDTH-1:0] : {acc_q[WIDTH-2:0], wrk_q[WIDTH-1]};
                    wrk_d = {wrk_q[WIDTH-2:0], as_carry};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 5'd1;
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!is_div) begin
                    {hi_d, lo_d} = (sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod : prod;
                end else if (b_q == '0) begin
                    lo_d = '1;
                    hi_d = a_q;
                end else begin
                    lo_d = neg_if(wrk_q, sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
                    hi_d = neg_if(acc_q, sgn && a_q[WIDTH-1]);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // NOTE: working registers are left unreset; they are always loaded at start before use.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        a_q    <= a_d;
        b_q    <= b_d;
        acc_q  <= acc_d;
        wrk_q  <= wrk_d;
        opnd_q <= opnd_d;
    end

    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: reset, mult/div results, fixed latency,
// divide corner cases, mthi/mtlo, start-while-busy and mid-operation reset.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, hi_we, lo_we;
    logic [1:0]  op;
    logic [31:0] a, b, wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the operand inputs, then wait (bounded) for done.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        start = 1'b1; op = o; a = x; b = y;
        tick();
        start = 1'b0; op = ~o; a = 32'h5A5A_A5A5; b = 32'h0F0F_F0F0;
        n = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (busy) n++;
            tick();
        end
        check({tag, " done"}, {31'b0, done}, 32'd1);
        check({tag, " busy_cycles"}, 32'(n), 32'd33);
        check({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        tick();
        check({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        check({tag, " hi_held"}, hi, ehi);
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset done", {31'b0, done}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);

        run_op("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("multu max*max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu 100/0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div -7/0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // mthi / mtlo while idle
        hi_we = 1'b1; wdata = 32'h1234_5678;
        tick();
        hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo_held", lo, 32'h8000_0000);
        tick();
        lo_we = 1'b0;
        check("mtlo lo", lo, 32'h9ABC_DEF0);
        check("mtlo hi_held", hi, 32'h1234_5678);

        // second start and mthi while busy are ignored
        start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd3;
        tick();
        start = 1'b0; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0;
        check("busy hi_we ignored", hi, 32'h1234_5678);
        ndone = 0;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                ndone++;
                check("overlap lo", lo, 32'd15);
                check("overlap hi", hi, 32'd0);
            end
            tick();
        end
        check("overlap single done", 32'(ndone), 32'd1);
        check("overlap idle after", {31'b0, busy}, 32'd0);

        // mthi in the same cycle as start; FIX overwrites it later
        start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3; hi_we = 1'b1; wdata = 32'hAAAA_5555;
        tick();
        start = 1'b0; hi_we = 1'b0;
        check("start+mthi hi", hi, 32'hAAAA_5555);
        for (int k = 0; k < 100 && !done; k++) tick();
        check("start+mthi done", {31'b0, done}, 32'd1);
        check("start+mthi fix hi", hi, 32'd0);
        check("start+mthi fix lo", lo, 32'd6);
        tick();

        // reset mid-operation aborts; rst wins over start/hi_we in the same cycle
        start = 1'b1; op = OP_MULT; a = 32'hFFFF_FFFC; b = 32'd9;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1; start = 1'b1; hi_we = 1'b1; wdata = 32'h7777_7777;
        tick();
        rst = 1'b0; start = 1'b0; hi_we = 1'b0;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort done", {31'b0, done}, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort lo", lo, 32'd0);
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) ndone++;
            tick();
        end
        check("abort no done", 32'(ndone), 32'd0);
        check("abort lo held", lo, 32'd0);
        run_op("multu 6*7 after reset", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
